sort_result_collector: RTL and testbench

Downstream consumer of the serial bubble-sort engine. Captures the sorted serial stream (one signed word per cycle while the sorter's data-valid is high) into a DEPTH-entry buffer. Exposes the result through a registered random-access read port, with frame status (count, done, min/max, overflow). Checks ascending order on the fly so that hardware sorter results can be self-checked on the bench and on the board.

---
 rtl/sort_result_collector.sv | 153 +++++++++++++++
 tb/tb_sort_result_collector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sort_result_collector.sv
// rtl/sort_result_collector.sv - capture buffer and frame status for the serial sorter output
//
// Purpose: stores one sorted serial frame (up to DEPTH signed words) and
// reports count, done, min/max, overflow and an ascending-order flag.
// Optional feature macro: SORT_CHECK_EN (on-the-fly order check).
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-low reset
//   data_serial_i signed word from the sorter
//   data_valid_i  data_serial_i valid this cycle
//   clear_i       drop the captured frame, return to IDLE
//   rd_addr_i     buffer read index
//   rd_data_o     registered buffer word at rd_addr_i (1-cycle latency)
//   count_o       words captured in the current frame
//   done_o        frame complete, buffer stable
//   min_o         first captured word
//   max_o         last captured word
//   overflow_o    sticky: valid word with no room or after done
//   sorted_ok_o   frame is non-decreasing (tied to 1 without SORT_CHECK_EN)

module sort_result_collector #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] data_serial_i,
  input  logic                    data_valid_i,
  input  logic                    clear_i,
  input  logic        [AW-1:0]    rd_addr_i,
  output logic signed [WIDTH-1:0] rd_data_o,
  output logic        [AW:0]      count_o,
  output logic                    done_o,
  output logic signed [WIDTH-1:0] min_o,
  output logic signed [WIDTH-1:0] max_o,
  output logic                    overflow_o,
  output logic                    sorted_ok_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [AW:0]             count_q;
  logic [AW:0]             count_inc;
  logic                    overflow_q;
  logic signed [WIDTH-1:0] min_q, max_q, rd_data_q;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic                    wr_en;

  assign count_inc = count_q + {{AW{1'b0}}, 1'b1};

  // Writes only while a frame can still accept data; clear drops the word.
  always_comb begin
    wr_en   = 1'b0;
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid_i) begin
            wr_en   = 1'b1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (data_valid_i) begin
            wr_en = 1'b1;
            if (count_inc == DEPTH_C) state_d = DONE;
          end else begin
            // valid falling edge ends the frame
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= mem[rd_addr_i];
      if (clear_i) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
        min_q      <= '0;
        max_q      <= '0;
      end else if (data_valid_i) begin
        case (state_q)
          IDLE: begin
            min_q   <= data_serial_i;
            max_q   <= data_serial_i;
            count_q <= {{AW{1'b0}}, 1'b1};
          end
          COLLECT: begin
            max_q   <= data_serial_i;
            count_q <= count_inc;
          end
          DONE:    overflow_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Buffer is not reset; count is 0 in IDLE so count_q addresses every write.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[count_q[AW-1:0]] <= data_serial_i;
  end

`ifdef SORT_CHECK_EN
  logic signed [WIDTH-1:0] prev_q;
  logic                    sorted_ok_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q      <= '0;
      sorted_ok_q <= 1'b1;
    end else if (clear_i) begin
      sorted_ok_q <= 1'b1;
    end else if (wr_en) begin
      prev_q <= data_serial_i;
      // first word of a frame (IDLE) has no predecessor to compare with
      if (state_q == COLLECT && data_serial_i < prev_q) sorted_ok_q <= 1'b0;
    end
  end

  assign sorted_ok_o = sorted_ok_q;
`else
  assign sorted_ok_o = 1'b1;
`endif

  assign rd_data_o  = rd_data_q;
  assign count_o    = count_q;
  assign done_o     = (state_q == DONE);
  assign min_o      = min_q;
  assign max_o      = max_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_sort_result_collector.sv
// tb/tb_sort_result_collector.sv - directed self-checking bench for sort_result_collector

module tb_sort_result_collector;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [WIDTH-1:0] data;
  logic                    valid;
  logic                    clear;
  logic        [AW-1:0]    addr;
  logic signed [WIDTH-1:0] rd_data;
  logic        [AW:0]      count;
  logic                    done;
  logic signed [WIDTH-1:0] min_v, max_v;
  logic                    overflow;
  logic                    sorted_ok;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sort_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_serial_i (data),
    .data_valid_i  (valid),
    .clear_i       (clear),
    .rd_addr_i     (addr),
    .rd_data_o     (rd_data),
    .count_o       (count),
    .done_o        (done),
    .min_o         (min_v),
    .max_o         (max_v),
    .overflow_o    (overflow),
    .sorted_ok_o   (sorted_ok)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // inputs change on the falling edge; outputs are checked on the next falling edge
  task automatic send(input int v);
    data  = v;
    valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_cycle();
    valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic read_check(input string tag, input int a, input int exp);
    addr = AW'(a);
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  int t1 [5] = '{-3, 0, 0, 7, 12};
  logic exp_sorted;

  initial begin
    rst = 1'b0; valid = 1'b0; data = '0; clear = 1'b0; addr = '0;
`ifdef SORT_CHECK_EN
    exp_sorted = 1'b0;
`else
    exp_sorted = 1'b1;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_sorted", 32'(sorted_ok), 1);
    check("rst_rd", rd_data, 0);
    check("rst_min", min_v, 0);
    check("rst_max", max_v, 0);
    rst = 1'b1;

    // short frame ended by valid dropping
    for (int i = 0; i < 5; i++) send(t1[i]);
    check("t1_done_early", 32'(done), 0);
    check("t1_count", 32'(count), 5);
    idle_cycle();
    check("t1_done", 32'(done), 1);
    check("t1_min", min_v, -3);
    check("t1_max", max_v, 12);
    check("t1_sorted", 32'(sorted_ok), 1);
    for (int i = 0; i < 5; i++) read_check($sformatf("t1_rd%0d", i), i, t1[i]);

    // full frame then an extra word
    clear_cycle();
    check("t2_clr_count", 32'(count), 0);
    check("t2_clr_done", 32'(done), 0);
    for (int i = 1; i <= 8; i++) send(i);
    check("t2_done", 32'(done), 1);
    check("t2_count", 32'(count), 8);
    check("t2_ovf_before", 32'(overflow), 0);
    send(99);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_count_frozen", 32'(count), 8);
    check("t2_max", max_v, 8);
    idle_cycle();
    check("t2_ovf_sticky", 32'(overflow), 1);
    read_check("t2_rd0", 0, 1);
    read_check("t2_rd7", 7, 8);

    // out-of-order stream
    clear_cycle();
    send(5);
    send(2);
    check("t3_sorted_after2", 32'(sorted_ok), 32'(exp_sorted));
    send(9);
    idle_cycle();
    check("t3_sorted_end", 32'(sorted_ok), 32'(exp_sorted));
    check("t3_min", min_v, 5);
    check("t3_max", max_v, 9);
    check("t3_done", 32'(done), 1);

    // clear wins over a valid word in DONE
    send(7);
    check("t4_ovf_set", 32'(overflow), 1);
    data = 4; valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; valid = 1'b0;
    check("t4_count", 32'(count), 0);
    check("t4_ovf", 32'(overflow), 0);
    check("t4_done", 32'(done), 0);
    check("t4_sorted", 32'(sorted_ok), 1);
    idle_cycle();
    check("t4_still_idle", 32'(count), 0);
    send(10);
    send(20);
    idle_cycle();
    check("t4_count2", 32'(count), 2);
    check("t4_min", min_v, 10);
    check("t4_max", max_v, 20);
    check("t4_done2", 32'(done), 1);
    read_check("t4_rd0", 0, 10);

    // reset mid-frame
    clear_cycle();
    send(1); send(2); send(3);
    check("t5_count3", 32'(count), 3);
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("t5_rst_count", 32'(count), 0);
    check("t5_rst_done", 32'(done), 0);
    rst = 1'b1;
    send(40);
    send(50);
    idle_cycle();
    check("t5_count", 32'(count), 2);
    check("t5_min", min_v, 40);
    check("t5_done", 32'(done), 1);
    read_check("t5_rd0", 0, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
